// File: rtl/mem_stage_ctrl_pkg.sv
// rtl/mem_stage_ctrl_pkg.sv - shared types and helpers for the MEM-stage memory controller
package mem_stage_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Number of low address bits that must be zero for a word-aligned access.
    function automatic int alignBits(input int dataW);
        return $clog2(dataW / 8);
    endfunction

    // A width of 64 makes the shift wrap to zero, so the mask still comes out all-ones.
    function automatic logic [63:0] satInc(input logic [63:0] value, input int width);
        logic [63:0] maxVal;
        maxVal = (64'd1 << width) - 64'd1;
        return (value >= maxVal) ? maxVal : value + 64'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter that sticks at all-ones
module sat_counter
    import mem_stage_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= WIDTH'(satInc(64'(count), WIDTH));
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - issues MEM-stage loads/stores once to a multi-cycle memory and stalls until done
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData,
    output logic              stallOut,
    output logic              errOut,
    output logic [CNT_W-1:0]  hitCount,
    output logic [CNT_W-1:0]  missCount,
    output logic              memRd,
    output logic              memWr,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memDataIn,
    input  logic [DATA_W-1:0] memDataOut,
    input  logic              memDone,
    input  logic              memStall,
    input  logic              memCacheHit,
    input  logic              memErr
);

    localparam int ALIGN = alignBits(DATA_W);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << ALIGN) - 1);
    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t            state;
    logic [ADDR_W-1:0] addrReg;
    logic [DATA_W-1:0] dataReg;
    logic              isRead;
    logic [TO_W-1:0]   toCnt;

    logic request;
    logic badReq;
    logic issue;
    logic doneAccept;
    logic unusedStall;

    // The memory only sees requests while this FSM is idle, so its stall flag never gates issue.
    assign unusedStall = memStall;

    always_comb begin
        request    = memRead | memWrite;
        badReq     = (memRead & memWrite) | (|(addr & ALIGN_MASK));
        issue      = (state == IDLE) && request && !badReq && !rst;
        doneAccept = memDone && (issue || (state == BUSY));
    end

    // Strobes and address are live in the issue cycle so the memory may answer in that same cycle.
    assign stallOut  = request && (state != RESP);
    assign memRd     = issue & memRead;
    assign memWr     = issue & memWrite;
    assign memAddr   = issue ? addr : addrReg;
    assign memDataIn = issue ? writeData : dataReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            readData <= '0;
            errOut   <= 1'b0;
            addrReg  <= '0;
            dataReg  <= '0;
            isRead   <= 1'b0;
            toCnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        if (badReq) begin
                            errOut   <= 1'b1;
                            readData <= '0;
                            state    <= RESP;
                        end else begin
                            addrReg <= addr;
                            dataReg <= writeData;
                            isRead  <= memRead;
                            toCnt   <= '0;
                            if (memDone) begin
                                if (memRead) readData <= memDataOut;
                                errOut <= memErr;
                                state  <= RESP;
                            end else begin
                                state <= BUSY;
                            end
                        end
                    end
                end
                BUSY: begin
                    if (memDone) begin
                        if (isRead) readData <= memDataOut;
                        errOut <= memErr;
                        state  <= RESP;
                    end else begin
                        toCnt <= toCnt + 1'b1;
                        if ((TIMEOUT != 0) && (toCnt == TO_LAST)) begin
                            errOut <= 1'b1;
                            state  <= RESP;
                        end
                    end
                end
                RESP: begin
                    errOut <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_W)) uHitCounter (
        .clk   (clk),
        .rst   (rst),
        .inc   (doneAccept & memCacheHit),
        .count (hitCount)
    );

    sat_counter #(.WIDTH(CNT_W)) uMissCounter (
        .clk   (clk),
        .rst   (rst),
        .inc   (doneAccept & ~memCacheHit),
        .count (missCount)
    );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - randomized self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int CNT_W   = 2;
    localparam int TIMEOUT = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              memRead = 1'b0;
    logic              memWrite = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] writeData = '0;
    logic [DATA_W-1:0] readData;
    logic              stallOut;
    logic              errOut;
    logic [CNT_W-1:0]  hitCount;
    logic [CNT_W-1:0]  missCount;
    logic              memRd;
    logic              memWr;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memDataIn;
    logic [DATA_W-1:0] memDataOut = '0;
    logic              memDone = 1'b0;
    logic              memStall = 1'b0;
    logic              memCacheHit = 1'b0;
    logic              memErr = 1'b0;

    int checks = 0;
    int passes = 0;

    // Reference model: outcome of each access derived from the access rules alone.
    logic [DATA_W-1:0] expRead = '0;
    int expHit = 0, expMiss = 0;
    int expStall, expRdP, expWrP;
    logic expErr;

    // Observations collected over one transaction.
    int obsStall, obsRd, obsWr, obsAddrBad;
    logic obsErr;
    logic [DATA_W-1:0] obsRead;
    logic [CNT_W-1:0] obsHit, obsMiss;

    mem_stage_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite), .addr(addr),
        .writeData(writeData), .readData(readData), .stallOut(stallOut), .errOut(errOut),
        .hitCount(hitCount), .missCount(missCount), .memRd(memRd), .memWr(memWr),
        .memAddr(memAddr), .memDataIn(memDataIn), .memDataOut(memDataOut), .memDone(memDone),
        .memStall(memStall), .memCacheHit(memCacheHit), .memErr(memErr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic predict(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                           input int doneAt, input logic hit, input logic err,
                           input logic [DATA_W-1:0] rdata);
        logic legal;
        legal = !(rd && wr) && ((int'(a) % (DATA_W / 8)) == 0);
        if (!legal) begin
            expStall = 1; expErr = 1'b1; expRead = '0; expRdP = 0; expWrP = 0;
        end else begin
            expRdP = int'(rd); expWrP = int'(wr);
            if (doneAt >= 0 && (TIMEOUT == 0 || doneAt <= TIMEOUT)) begin
                expStall = doneAt + 1;
                expErr = err;
                if (rd) expRead = rdata;
                if (hit) expHit = (expHit < CNT_MAX) ? expHit + 1 : CNT_MAX;
                else     expMiss = (expMiss < CNT_MAX) ? expMiss + 1 : CNT_MAX;
            end else begin
                expStall = TIMEOUT + 1;
                expErr = 1'b1;
            end
        end
    endtask

    // Entered and left just after a rising edge; the memory answers doneAt cycles after the request appears.
    task automatic runTxn(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] wd, input int doneAt, input logic hit,
                          input logic err, input logic [DATA_W-1:0] rdata);
        int cyc;
        logic legal;
        legal = !(rd && wr) && ((int'(a) % (DATA_W / 8)) == 0);
        memRead = rd; memWrite = wr; addr = a; writeData = wd;
        obsStall = 0; obsRd = 0; obsWr = 0; obsAddrBad = 0; cyc = 0;
        forever begin
            memDone     = (cyc == doneAt);
            memDataOut  = (cyc == doneAt) ? rdata : DATA_W'($urandom);
            memCacheHit = (cyc == doneAt) ? hit : 1'($urandom);
            memErr      = (cyc == doneAt) ? err : 1'($urandom);
            memStall    = 1'($urandom);
            @(negedge clk);
            obsRd += int'(memRd);
            obsWr += int'(memWr);
            if (!stallOut) break;
            obsStall++;
            if (legal && (memAddr !== a || (wr && memDataIn !== wd))) obsAddrBad++;
            @(posedge clk); #1;
            cyc++;
            if (cyc > 60) break;
        end
        obsErr = errOut; obsRead = readData; obsHit = hitCount; obsMiss = missCount;
        @(posedge clk); #1;
        memRead = 1'b0; memWrite = 1'b0; memDone = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; memRead = 1'b0; memWrite = 1'b0;
        repeat (3) @(posedge clk);
        #1 memRead = 1'b1; addr = 16'h0010;
        @(negedge clk);
        checks++; if (stallOut !== 1'b1) $display("FAIL reset_stall_req: got %0b want 1", stallOut); else passes++;
        @(posedge clk); #1;
        rst = 1'b0; memRead = 1'b0;
        @(negedge clk);
        checks++;
        if ({readData, errOut, memRd, memWr, memAddr, memDataIn, hitCount, missCount, stallOut} !== '0)
            $display("FAIL reset_values: got rd=%h err=%b strobes=%b%b addr=%h din=%h hit=%0d miss=%0d stall=%b want all 0",
                     readData, errOut, memRd, memWr, memAddr, memDataIn, hitCount, missCount, stallOut);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_load_hit_issue();
        runTxn(1'b1, 1'b0, 16'h0010, 16'h5555, 0, 1'b1, 1'b0, 16'hBEEF);
        predict(1'b1, 1'b0, 16'h0010, 0, 1'b1, 1'b0, 16'hBEEF);
        checks++; if (obsStall !== 1) $display("FAIL hit_stall: got %0d want 1", obsStall); else passes++;
        checks++; if (obsRead !== 16'hBEEF) $display("FAIL hit_data: got %h want beef", obsRead); else passes++;
        checks++; if (int'(obsHit) !== expHit) $display("FAIL hit_count: got %0d want %0d", obsHit, expHit); else passes++;
        checks++; if (obsRd !== 1) $display("FAIL hit_rd_pulses: got %0d want 1", obsRd); else passes++;
        checks++; if (obsErr !== 1'b0) $display("FAIL hit_err: got %0b want 0", obsErr); else passes++;
    endtask

    task automatic test_load_miss();
        runTxn(1'b1, 1'b0, 16'h0020, 16'h0000, 4, 1'b0, 1'b0, 16'h1234);
        predict(1'b1, 1'b0, 16'h0020, 4, 1'b0, 1'b0, 16'h1234);
        checks++; if (obsStall !== 5) $display("FAIL miss_stall: got %0d want 5", obsStall); else passes++;
        checks++; if (obsRd !== 1) $display("FAIL miss_rd_pulses: got %0d want 1", obsRd); else passes++;
        checks++; if (int'(obsMiss) !== expMiss) $display("FAIL miss_count: got %0d want %0d", obsMiss, expMiss); else passes++;
        checks++; if (obsRead !== 16'h1234) $display("FAIL miss_data: got %h want 1234", obsRead); else passes++;
        checks++; if (obsAddrBad !== 0) $display("FAIL miss_addr_hold: got %0d bad cycles want 0", obsAddrBad); else passes++;
    endtask

    task automatic test_errors();
        runTxn(1'b0, 1'b1, 16'h0021, 16'hAAAA, 0, 1'b1, 1'b0, 16'h0000);
        predict(1'b0, 1'b1, 16'h0021, 0, 1'b1, 1'b0, 16'h0000);
        checks++; if (obsWr !== 0) $display("FAIL misalign_wr_pulses: got %0d want 0", obsWr); else passes++;
        checks++; if (obsStall !== expStall) $display("FAIL misalign_stall: got %0d want %0d", obsStall, expStall); else passes++;
        checks++; if (obsErr !== 1'b1) $display("FAIL misalign_err: got %0b want 1", obsErr); else passes++;
        checks++; if (obsRead !== expRead) $display("FAIL misalign_data: got %h want %h", obsRead, expRead); else passes++;
        checks++; if (int'(obsHit) !== expHit) $display("FAIL misalign_count: got %0d want %0d", obsHit, expHit); else passes++;
        runTxn(1'b1, 1'b1, 16'h0040, 16'h7777, 1, 1'b0, 1'b0, 16'h4321);
        predict(1'b1, 1'b1, 16'h0040, 1, 1'b0, 1'b0, 16'h4321);
        checks++; if (obsRd + obsWr !== 0) $display("FAIL illegal_pulses: got %0d want 0", obsRd + obsWr); else passes++;
        checks++; if (obsErr !== 1'b1 || obsStall !== 1) $display("FAIL illegal_resp: got err=%0b stall=%0d want err=1 stall=1", obsErr, obsStall); else passes++;
        runTxn(1'b0, 1'b1, 16'h0042, 16'h9876, 2, 1'b0, 1'b0, 16'hFFFF);
        predict(1'b0, 1'b1, 16'h0042, 2, 1'b0, 1'b0, 16'hFFFF);
        checks++; if (obsErr !== 1'b0) $display("FAIL store_after_err: got err=%0b want 0", obsErr); else passes++;
        checks++; if (obsRead !== expRead) $display("FAIL store_keeps_data: got %h want %h", obsRead, expRead); else passes++;
        checks++; if (obsWr !== 1 || obsAddrBad !== 0) $display("FAIL store_issue: got wr=%0d bad=%0d want wr=1 bad=0", obsWr, obsAddrBad); else passes++;
    endtask

    task automatic test_timeout();
        runTxn(1'b1, 1'b0, 16'h0080, 16'h0000, TIMEOUT + 1, 1'b1, 1'b0, 16'hCAFE);
        predict(1'b1, 1'b0, 16'h0080, TIMEOUT + 1, 1'b1, 1'b0, 16'hCAFE);
        checks++; if (obsStall !== TIMEOUT + 1) $display("FAIL timeout_stall: got %0d want %0d", obsStall, TIMEOUT + 1); else passes++;
        checks++; if (obsErr !== 1'b1) $display("FAIL timeout_err: got %0b want 1", obsErr); else passes++;
        checks++; if (int'(obsHit) !== expHit || int'(obsMiss) !== expMiss) $display("FAIL timeout_counts: got %0d/%0d want %0d/%0d", obsHit, obsMiss, expHit, expMiss); else passes++;
        checks++; if (obsRead !== expRead) $display("FAIL timeout_data: got %h want %h", obsRead, expRead); else passes++;
        memDone = 1'b1; memCacheHit = 1'b1;
        @(posedge clk); #1 memDone = 1'b0;
        @(negedge clk);
        checks++; if (int'(hitCount) !== expHit || int'(missCount) !== expMiss) $display("FAIL idle_done_ignored: got %0d/%0d want %0d/%0d", hitCount, missCount, expHit, expMiss); else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            logic [DATA_W-1:0] d;
            int dl;
            d = DATA_W'($urandom);
            dl = $urandom_range(0, 2);
            runTxn(1'b1, 1'b0, 16'h0100, 16'h0000, dl, 1'b1, 1'b0, d);
            predict(1'b1, 1'b0, 16'h0100, dl, 1'b1, 1'b0, d);
        end
        checks++; if (obsHit !== 2'd3) $display("FAIL hit_saturate: got %0d want 3", obsHit); else passes++;
        checks++; if (int'(obsHit) !== expHit) $display("FAIL hit_saturate_model: got %0d want %0d", obsHit, expHit); else passes++;
    endtask

    task automatic test_reset_busy();
        memRead = 1'b1; addr = 16'h0200; memDone = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; memRead = 1'b0;
        expRead = '0; expHit = 0; expMiss = 0;
        @(negedge clk);
        checks++;
        if ({readData, errOut, memRd, memWr, memAddr, memDataIn, hitCount, missCount, stallOut} !== '0)
            $display("FAIL reset_in_busy: got rd=%h err=%b strobes=%b%b addr=%h din=%h hit=%0d miss=%0d stall=%b want all 0",
                     readData, errOut, memRd, memWr, memAddr, memDataIn, hitCount, missCount, stallOut);
        else passes++;
        @(posedge clk); #1;
        runTxn(1'b1, 1'b0, 16'h0300, 16'h0000, 1, 1'b0, 1'b0, 16'h0F0F);
        predict(1'b1, 1'b0, 16'h0300, 1, 1'b0, 1'b0, 16'h0F0F);
        checks++; if (obsRd !== 1 || obsStall !== 2) $display("FAIL post_reset_issue: got rd=%0d stall=%0d want 1/2", obsRd, obsStall); else passes++;
        checks++; if (obsRead !== expRead || int'(obsMiss) !== expMiss) $display("FAIL post_reset_result: got %h/%0d want %h/%0d", obsRead, obsMiss, expRead, expMiss); else passes++;
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 40; i++) begin
            logic rd, wr, hit, err;
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] wd, d;
            int kind, dl;
            kind = $urandom_range(0, 9);
            rd = (kind < 5) || (kind == 9);
            wr = (kind >= 5);
            a = ADDR_W'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 5) == 0) a = a | 16'h0001;
            wd = DATA_W'($urandom); d = DATA_W'($urandom);
            dl = $urandom_range(0, TIMEOUT + 2);
            hit = 1'($urandom); err = ($urandom_range(0, 7) == 0);
            runTxn(rd, wr, a, wd, dl, hit, err, d);
            predict(rd, wr, a, dl, hit, err, d);
            checks++; if (obsStall !== expStall) $display("FAIL rnd%0d_stall: got %0d want %0d", i, obsStall, expStall); else passes++;
            checks++; if (obsErr !== expErr) $display("FAIL rnd%0d_err: got %0b want %0b", i, obsErr, expErr); else passes++;
            checks++; if (obsRead !== expRead) $display("FAIL rnd%0d_data: got %h want %h", i, obsRead, expRead); else passes++;
            checks++; if (int'(obsHit) !== expHit || int'(obsMiss) !== expMiss) $display("FAIL rnd%0d_counts: got %0d/%0d want %0d/%0d", i, obsHit, obsMiss, expHit, expMiss); else passes++;
            checks++; if (obsRd !== expRdP || obsWr !== expWrP) $display("FAIL rnd%0d_strobes: got %0d/%0d want %0d/%0d", i, obsRd, obsWr, expRdP, expWrP); else passes++;
            checks++; if (obsAddrBad !== 0) $display("FAIL rnd%0d_addr_hold: got %0d bad cycles want 0", i, obsAddrBad); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_load_hit_issue();
        test_load_miss();
        test_errors();
        test_timeout();
        test_saturation();
        test_reset_busy();
        test_back_to_back_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
